fp_div_param: RTL and testbench
===============================

# fp_div_param

Parametrised IEEE-754 floating-point divider: computes z = a / b for any binary format set by EXP_W/MAN_W (half, single, double). Multi-cycle radix-2 restoring datapath with strt/busy/done handshake, round-to-nearest-even and exception flags. Replaces the fixed double-precision divider and is the divide unit in the FP arithmetic cluster.

## Interface
- EXP_W, 11: exponent field width.
- MAN_W, 52: stored fraction width, excluding hidden bit; word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- strt  in  1  start request; sampled only in IDLE.
- a  in  W  dividend.
- b  in  W  divisor.
- z  out  W  result; held until the next done.
- busy  out  1  high from the edge after strt is accepted until done.
- done  out  1  single-cycle pulse; z and flags are valid in that cycle.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}; held with z.

## Operation
- States: IDLE, UNPACK, DIVIDE, NORM, ROUND.
- IDLE: strt=1 latches a and b, goes to UNPACK. strt is ignored in every other state.
- UNPACK:
  - splits sign, exponent and mantissa; sign = sa^sb.
  - subnormal inputs are treated as signed zero.
  - classifies operands. Special cases go straight to ROUND with a fixed result:
    - any NaN: canonical qNaN (exp all-ones, fraction MSB 1, sign 0). invalid is set only if an input is sNaN.
    - 0/0 or inf/inf: qNaN, invalid.
    - finite nonzero/0: signed inf, div_by_zero.
    - inf/finite: signed inf.
    - 0/nonzero or finite/inf: signed zero.
  - otherwise loads remainder = 1.ma, divisor = 1.mb, step counter = MAN_W+4, exp = ea − eb + BIAS, where BIAS = 2^(EXP_W−1)−1. exp is kept at signed width EXP_W+2.
- DIVIDE: one quotient bit per cycle, MSB first. Each cycle:
  - trial = rem − div.
  - if trial ≥ 0: q_bit = 1, rem = trial << 1.
  - else: q_bit = 0, rem = rem << 1.
  - counter decrements; leave DIVIDE when it reaches 0. Total MAN_W+4 quotient bits.
- NORM: if the quotient MSB is 0 (q < 1), shift the quotient left by 1 and exp −= 1. Sticky = (rem ≠ 0).
- ROUND:
  - RNE on guard/round/sticky. A mantissa carry-out sets the fraction to 0 and exp += 1.
  - exp ≥ all-ones: signed inf, overflow + inexact.
  - exp ≤ 0: signed zero, underflow + inexact (flush-to-zero).
  - inexact = guard | round | sticky for normal results.
  - registers z and flags, pulses done, returns to IDLE.
- A new strt may be accepted in the IDLE cycle right after done; back-to-back operations are allowed.

## Timing
- The edge that samples strt is edge 0.
- Normal operands: UNPACK 1 cycle, DIVIDE MAN_W+4, NORM 1, ROUND 1. done is high after edge MAN_W+7 (59 for double, 30 for single, 17 for half).
- Special operands: done is high after edge 2.
- busy rises after edge 0 and falls on the same edge that raises done.
- Reset values: z=0, flags=0, busy=0, done=0, state IDLE.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation, and z keeps its reset value 0.
- Changing a or b while busy has no effect.

## Structure
- Package fp_div_pkg holds:
  - state enum;
  - flag bit index constants (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0);
  - operand class enum (ZERO, NORM, INF, QNAN, SNAN).
- Sub-module fp_div_round (combinational, parametrised EXP_W/MAN_W) does RNE rounding, overflow/underflow detection and packing. It is instantiated once, in the ROUND stage.

## Test plan
- Double 6.0/3.0: a=0x4018000000000000, b=0x4008000000000000 → z=0x4000000000000000, flags=0, done after edge 59, busy high for edges 1–58.
- Double 1/3: a=0x3FF0000000000000, b=0x4008000000000000 → z=0x3FD5555555555555, flags=0b00001.
- Specials, done after edge 2:
  - 1.0/+0 → 0x7FF0000000000000, flags=0b01000.
  - 0/0 → 0x7FF8000000000000, flags=0b10000.
- Overflow: a=0x7FE0000000000000, b=0x3FE0000000000000 → z=0x7FF0000000000000, flags=0b00101.
- Handshake and reset:
  - strt pulsed while busy is ignored.
  - reset low at edge 20 of an operation: no done, z=0.
  - a fresh strt after release completes normally.
- Single precision (EXP_W=8, MAN_W=23): 3.0/2.0 → a=0x40400000, b=0x40000000 → z=0x3FC00000, done after edge 30.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the parametrised floating-point divider.
package fp_div_pkg;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND} state_t;

  typedef enum logic [2:0] {C_ZERO, C_NORM, C_INF, C_QNAN, C_SNAN} cls_t;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

endpackage

// File: rtl/fp_div_param_if.sv
// Start/operand/result bundle between a requester and the divider.
interface fp_div_param_if #(parameter int W = 64);
  logic         strt;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] z;
  logic         busy;
  logic         done;
  logic [4:0]   flags;

  modport master (output strt, a, b, input z, busy, done, flags);
  modport slave  (input strt, a, b, output z, busy, done, flags);
endinterface

// File: rtl/fp_div_round.sv
// Combinational RNE rounding, overflow/underflow (flush-to-zero) and packing.
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                     i_sign,
  input  logic signed [EXP_W+1:0]  i_exp,
  input  logic [MAN_W:0]           i_mant,
  input  logic                     i_g,
  input  logic                     i_r,
  input  logic                     i_s,
  output logic [EXP_W+MAN_W:0]     o_z,
  output logic [4:0]               o_flags
);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MIN = '0;

  logic                    w_inc;
  logic [MAN_W+1:0]        w_sum;
  logic signed [EXP_W+1:0] w_exp;

  always_comb begin
    w_inc = i_g & (i_r | i_s | i_mant[0]);
    w_sum = {1'b0, i_mant} + {{(MAN_W+1){1'b0}}, w_inc};
    // a carry-out leaves the fraction bits all zero, so only the exponent moves
    w_exp = i_exp + $signed({{(EXP_W+1){1'b0}}, w_sum[MAN_W+1]});
    o_flags = '0;
    o_flags[FLG_NX] = i_g | i_r | i_s;
    o_z = {i_sign, w_exp[EXP_W-1:0], w_sum[MAN_W-1:0]};
    if (w_exp >= EXP_MAX) begin
      o_z = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags[FLG_OF] = 1'b1;
      o_flags[FLG_NX] = 1'b1;
    end else if (w_exp <= EXP_MIN) begin
      o_z = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      o_flags[FLG_UF] = 1'b1;
      o_flags[FLG_NX] = 1'b1;
    end
  end
endmodule

// File: rtl/fp_div_param.sv
// Multi-cycle radix-2 restoring IEEE-754 divider, format set by EXP_W/MAN_W.
module fp_div_param
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input logic           clk,
  input logic           reset,
  fp_div_param_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

  state_t                r_state, w_nxt;
  logic [W-1:0]          r_a, r_b, r_z, r_spc_z;
  logic [4:0]            r_flags, r_spc_flags;
  logic                  r_busy, r_done, r_sign, r_spc, r_stk;
  logic signed [EW-1:0]  r_exp;
  logic [MAN_W+1:0]      r_rem;
  logic [MAN_W:0]        r_div;
  logic [QW-1:0]         r_q;
  logic [CW-1:0]         r_cnt;

  cls_t                  w_ca, w_cb;
  logic                  w_sign, w_spc;
  logic [W-1:0]          w_spc_z, w_rz;
  logic [4:0]            w_spc_flags, w_rflags;
  logic [MAN_W+2:0]      w_trial;

  // subnormals classify as zero (flush-to-zero on input)
  function automatic cls_t classify(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0) return C_ZERO;
    if (x[W-2:MAN_W] != '1) return C_NORM;
    if (x[MAN_W-1:0] == '0) return C_INF;
    return x[MAN_W-1] ? C_QNAN : C_SNAN;
  endfunction

  always_comb begin
    w_ca        = classify(r_a);
    w_cb        = classify(r_b);
    w_sign      = r_a[W-1] ^ r_b[W-1];
    w_spc       = 1'b1;
    w_spc_flags = '0;
    w_spc_z     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    if (w_ca inside {C_QNAN, C_SNAN} || w_cb inside {C_QNAN, C_SNAN}) begin
      w_spc_flags[FLG_NV] = (w_ca == C_SNAN) || (w_cb == C_SNAN);
    end else if ((w_ca == C_ZERO && w_cb == C_ZERO) || (w_ca == C_INF && w_cb == C_INF)) begin
      w_spc_flags[FLG_NV] = 1'b1;
    end else if (w_ca == C_INF) begin
      w_spc_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_cb == C_ZERO) begin
      w_spc_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spc_flags[FLG_DZ] = 1'b1;
    end else if (w_ca == C_ZERO || w_cb == C_INF) begin
      w_spc_z = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_spc = 1'b0;
    end
  end

  // sign bit of the extended difference decides the quotient bit
  assign w_trial = {1'b0, r_rem} - {2'b00, r_div};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.strt) w_nxt = S_UNPACK;
      S_UNPACK: w_nxt = w_spc ? S_ROUND : S_DIVIDE;
      S_DIVIDE: if (r_cnt == CW'(1)) w_nxt = S_NORM;
      S_NORM:   w_nxt = S_ROUND;
      S_ROUND:  w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0; r_b <= '0; r_z <= '0; r_spc_z <= '0;
      r_flags <= '0; r_spc_flags <= '0;
      r_busy <= 1'b0; r_done <= 1'b0; r_sign <= 1'b0; r_spc <= 1'b0; r_stk <= 1'b0;
      r_exp <= '0; r_rem <= '0; r_div <= '0; r_q <= '0; r_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.strt) begin
          r_a    <= bus.a;
          r_b    <= bus.b;
          r_busy <= 1'b1;
        end
        S_UNPACK: begin
          r_sign      <= w_sign;
          r_spc       <= w_spc;
          r_spc_z     <= w_spc_z;
          r_spc_flags <= w_spc_flags;
          r_rem       <= {1'b0, 1'b1, r_a[MAN_W-1:0]};
          r_div       <= {1'b1, r_b[MAN_W-1:0]};
          r_q         <= '0;
          r_cnt       <= CW'(QW);
          r_exp       <= $signed({2'b00, r_a[W-2:MAN_W]}) - $signed({2'b00, r_b[W-2:MAN_W]}) + BIAS;
        end
        S_DIVIDE: begin
          r_q   <= {r_q[QW-2:0], ~w_trial[MAN_W+2]};
          r_rem <= w_trial[MAN_W+2] ? {r_rem[MAN_W:0], 1'b0} : {w_trial[MAN_W:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
        end
        S_NORM: begin
          r_stk <= |r_rem;
          if (!r_q[QW-1]) begin
            r_q   <= {r_q[QW-2:0], 1'b0};
            r_exp <= r_exp - EW'(1);
          end
        end
        S_ROUND: begin
          r_z     <= r_spc ? r_spc_z : w_rz;
          r_flags <= r_spc ? r_spc_flags : w_rflags;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // quotient LSB is the third bit below the round position; it folds into sticky
  fp_div_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .i_sign  (r_sign),
    .i_exp   (r_exp),
    .i_mant  (r_q[QW-1:3]),
    .i_g     (r_q[2]),
    .i_r     (r_q[1]),
    .i_s     (r_q[0] | r_stk),
    .o_z     (w_rz),
    .o_flags (w_rflags)
  );

  assign bus.z     = r_z;
  assign bus.flags = r_flags;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_fp_div_param.sv
// Directed + random checks of fp_div_param in double and single precision.
module tb_fp_div_param;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_div_param_if #(.W(64)) dp_if ();
  fp_div_param_if #(.W(32)) sp_if ();

  fp_div_param #(.EXP_W(11), .MAN_W(52)) u_dp (.clk(clk), .reset(rst_n), .bus(dp_if.slave));
  fp_div_param #(.EXP_W(8),  .MAN_W(23)) u_sp (.clk(clk), .reset(rst_n), .bus(sp_if.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_done(input bit sp);
    return sp ? sp_if.done : dp_if.done;
  endfunction
  function automatic bit f_busy(input bit sp);
    return sp ? sp_if.busy : dp_if.busy;
  endfunction

  // class codes: 0 zero/subnormal, 1 normal, 2 inf, 3 qNaN, 4 sNaN
  function automatic int cls(input longint e, input logic [63:0] f, input longint emax, input int mw);
    if (e == 0) return 0;
    if (e != emax) return 1;
    if (f == 0) return 2;
    return f[mw-1] ? 3 : 4;
  endfunction

  // Reference: exact long division with wide integers, then RNE on the remainder bits.
  task automatic model(input int ew, input int mw, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] z, output logic [4:0] fl, output int lat);
    longint emax, ea, eb, e;
    int ca, cb, sh;
    bit s, inc, nx;
    logic [63:0]  emask, fmask, qnan, inf, zero;
    logic [127:0] ma, mb, q, r, mant, rest, half;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    emax  = longint'(emask);
    ea = longint'((a >> mw) & emask);
    eb = longint'((b >> mw) & emask);
    s  = a[ew+mw] ^ b[ew+mw];
    qnan = (emask << mw) | (64'd1 << (mw-1));
    zero = {63'd0, s} << (ew+mw);
    inf  = zero | (emask << mw);
    ca = cls(ea, a & fmask, emax, mw);
    cb = cls(eb, b & fmask, emax, mw);
    fl = '0;
    lat = 2;
    if (ca >= 3 || cb >= 3) begin z = qnan; fl[4] = (ca == 4 || cb == 4); end
    else if ((ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin z = qnan; fl[4] = 1'b1; end
    else if (ca == 2) z = inf;
    else if (cb == 0) begin z = inf; fl[3] = 1'b1; end
    else if (ca == 0 || cb == 2) z = zero;
    else begin
      lat = mw + 7;
      ma = 128'(a & fmask) | (128'd1 << mw);
      mb = 128'(b & fmask) | (128'd1 << mw);
      q = (ma << (mw+8)) / mb;
      r = (ma << (mw+8)) % mb;
      e = ea - eb + (emax >> 1);
      if ((q >> (mw+8)) != 0) sh = 8;
      else begin sh = 7; e = e - 1; end
      mant = q >> sh;
      rest = q & ((128'd1 << sh) - 1);
      half = 128'd1 << (sh-1);
      nx  = (rest != 0) || (r != 0);
      inc = (rest > half) || (rest == half && (r != 0 || mant[0]));
      mant = mant + 128'(inc);
      if ((mant >> (mw+1)) != 0) begin mant = mant >> 1; e = e + 1; end
      if (e >= emax) begin z = inf; fl = 5'b00101; end
      else if (e <= 0) begin z = zero; fl = 5'b00011; end
      else begin z = zero | (64'(e) << mw) | (mant[63:0] & fmask); fl = {4'b0, nx}; end
    end
  endtask

  function automatic logic [63:0] gen(input int ew, input int mw);
    logic [63:0] emask, fmask, f, e, s;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    f = {$urandom, $urandom} & fmask;
    s = 64'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0: begin e = 0; f = 0; end
      1: begin e = emask; f = 0; end
      2: begin e = emask; f = f | (64'd1 << (mw-1)); end
      3: begin e = emask; f = (f & ~(64'd1 << (mw-1))) | 64'd1; end
      4: e = 0;
      5: begin e = 64'($urandom_range(1, 32'(emask) - 1)); f = 0; end
      default: e = 64'($urandom_range(1, 32'(emask) - 1));
    endcase
    return (s << (ew+mw)) | (e << mw) | (f & fmask);
  endfunction

  // Starts at a negedge, returns at the negedge where done is seen (or on timeout, lat=-1).
  task automatic run(input bit sp, input logic [63:0] a, input logic [63:0] b, input int pulse_at,
                     output logic [63:0] z, output logic [4:0] fl, output int lat, output bit bok);
    if (sp) begin sp_if.a = a[31:0]; sp_if.b = b[31:0]; sp_if.strt = 1'b1; end
    else    begin dp_if.a = a;       dp_if.b = b;       dp_if.strt = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    sp_if.strt = 1'b0; dp_if.strt = 1'b0;
    bok = f_busy(sp) && !f_done(sp);
    lat = -1; z = '0; fl = '0;
    for (int n = 1; n <= 200; n++) begin
      if (n == pulse_at) begin
        if (sp) begin sp_if.a = ~sp_if.a; sp_if.b = ~sp_if.b; sp_if.strt = 1'b1; end
        else    begin dp_if.a = ~dp_if.a; dp_if.b = ~dp_if.b; dp_if.strt = 1'b1; end
      end
      @(posedge clk);
      @(negedge clk);
      sp_if.strt = 1'b0; dp_if.strt = 1'b0;
      if (f_done(sp)) begin
        lat = n;
        z  = sp ? {32'd0, sp_if.z} : dp_if.z;
        fl = sp ? sp_if.flags : dp_if.flags;
        if (f_busy(sp)) bok = 1'b0;
        break;
      end
      if (!f_busy(sp)) bok = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] z, ez, ra, rb;
    logic [4:0]  fl, efl;
    int          lat, elat;
    bit          bok, seen, sp;

    rst_n = 1'b0;
    dp_if.strt = 1'b0; dp_if.a = '0; dp_if.b = '0;
    sp_if.strt = 1'b0; sp_if.a = '0; sp_if.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_z",     dp_if.z, 64'd0);
    chk("rst_flags", 64'(dp_if.flags), 64'd0);
    chk("rst_busy",  64'(dp_if.busy), 64'd0);
    chk("rst_done",  64'(dp_if.done), 64'd0);
    chk("rst_sp_z",  64'(sp_if.z), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 64'h4018000000000000, 64'h4008000000000000, 0, z, fl, lat, bok);
    chk("d6_3_z", z, 64'h4000000000000000);
    chk("d6_3_flags", 64'(fl), 64'd0);
    chk("d6_3_lat", 64'(lat), 64'd59);
    chk("d6_3_busy", 64'(bok), 64'd1);

    run(0, 64'h3FF0000000000000, 64'h4008000000000000, 0, z, fl, lat, bok);
    chk("d1_3_z", z, 64'h3FD5555555555555);
    chk("d1_3_flags", 64'(fl), 64'b00001);
    chk("d1_3_lat", 64'(lat), 64'd59);

    run(0, 64'h3FF0000000000000, 64'h0000000000000000, 0, z, fl, lat, bok);
    chk("d1_0_z", z, 64'h7FF0000000000000);
    chk("d1_0_flags", 64'(fl), 64'b01000);
    chk("d1_0_lat", 64'(lat), 64'd2);

    run(0, 64'h0000000000000000, 64'h0000000000000000, 0, z, fl, lat, bok);
    chk("d0_0_z", z, 64'h7FF8000000000000);
    chk("d0_0_flags", 64'(fl), 64'b10000);
    chk("d0_0_lat", 64'(lat), 64'd2);

    run(0, 64'h7FE0000000000000, 64'h3FE0000000000000, 0, z, fl, lat, bok);
    chk("dovf_z", z, 64'h7FF0000000000000);
    chk("dovf_flags", 64'(fl), 64'b00101);
    chk("dovf_lat", 64'(lat), 64'd59);

    // strt (with different operands) pulsed mid-operation must be ignored
    run(0, 64'h4018000000000000, 64'h4008000000000000, 10, z, fl, lat, bok);
    chk("ign_z", z, 64'h4000000000000000);
    chk("ign_lat", 64'(lat), 64'd59);
    chk("ign_busy", 64'(bok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ign_no_rerun_busy", 64'(dp_if.busy), 64'd0);
    chk("ign_no_rerun_done", 64'(dp_if.done), 64'd0);

    // reset asserted at edge 20 of an operation
    dp_if.a = 64'h4018000000000000; dp_if.b = 64'h4008000000000000; dp_if.strt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dp_if.strt = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_z", dp_if.z, 64'd0);
    chk("abort_busy", 64'(dp_if.busy), 64'd0);
    chk("abort_done", 64'(dp_if.done), 64'd0);
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (dp_if.done) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (dp_if.done) seen = 1'b1; end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_z_hold", dp_if.z, 64'd0);

    run(0, 64'h3FF0000000000000, 64'h4008000000000000, 0, z, fl, lat, bok);
    chk("fresh_z", z, 64'h3FD5555555555555);
    chk("fresh_lat", 64'(lat), 64'd59);

    run(1, 64'h40400000, 64'h40000000, 0, z, fl, lat, bok);
    chk("s3_2_z", z, 64'h3FC00000);
    chk("s3_2_flags", 64'(fl), 64'd0);
    chk("s3_2_lat", 64'(lat), 64'd30);

    for (int i = 0; i < 60; i++) begin
      sp = i[0];
      if (sp) begin ra = gen(8, 23);  rb = gen(8, 23);  model(8, 23, ra, rb, ez, efl, elat); end
      else    begin ra = gen(11, 52); rb = gen(11, 52); model(11, 52, ra, rb, ez, efl, elat); end
      run(sp, ra, rb, 0, z, fl, lat, bok);
      chk(sp ? "rnd_sp_z" : "rnd_dp_z", z, ez);
      chk(sp ? "rnd_sp_flags" : "rnd_dp_flags", 64'(fl), 64'(efl));
      chk(sp ? "rnd_sp_lat" : "rnd_dp_lat", 64'(lat), 64'(elat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
